// File: rtl/seq_shift_add_mult_if.sv
// Handshake and data bundle for the sequential shift-and-add multiplier.
// The master side supplies operands and accepts products. The slave side is the multiplier.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sgn;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Radix-2 sequential multiplier that retires one multiplier bit per clock.
// It supports unsigned or two's-complement operands, selected per operation,
// and produces the full 2*WIDTH-bit product.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | WIDTH shift-and-add steps, busy high
// DONE  | product held on p, out_valid high until out_ready
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_shift_add_mult_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  // Two guard bits: one holds the unsigned carry, one holds the sign of a signed partial sum.
  localparam int ACC_W = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [ACC_W-1:0]     acc, acc_nxt, addend, sum;
  logic [WIDTH-1:0]     mcand, q, q_nxt;
  logic                 sgn_r;
  logic [CNT_W-1:0]     cnt;
  logic                 last;
  logic [2*WIDTH-1:0]   p_r;

  assign last          = (cnt == CNT_W'(WIDTH - 1));
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.p         = p_r;

  // One arithmetic step. In signed mode the multiplier MSB carries negative weight, so the last step subtracts.
  always_comb begin
    addend = sgn_r ? {{2{mcand[WIDTH-1]}}, mcand} : {2'b00, mcand};
    sum    = acc;
    if (q[0]) begin
      if (sgn_r && last) sum = acc - addend;
      else               sum = acc + addend;
    end
    acc_nxt = {sgn_r & sum[ACC_W-1], sum[ACC_W-1:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Input and output handshakes never overlap because in_ready is low in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then step the multiplier. p updates only when a product completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      q     <= '0;
      mcand <= '0;
      sgn_r <= 1'b0;
      cnt   <= '0;
      p_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand <= bus.a;
            q     <= bus.b;
            sgn_r <= bus.sgn;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) p_r <= {acc_nxt[WIDTH-1:0], q_nxt};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and random bench for seq_shift_add_mult at WIDTH=8.
// Expected products go into a queue when operands are driven.
// They are popped and compared when the product is handed over.
module tb_seq_shift_add_mult;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2*W-1:0] sb[$];

  seq_shift_add_mult_if #(.WIDTH(W)) bus();

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    longint ix, iy;
    if (s) begin
      ix = longint'($signed(x));
      iy = longint'($signed(y));
    end else begin
      ix = longint'(x);
      iy = longint'(y);
    end
    return (2*W)'(ix * iy);
  endfunction

  // Runs one operation: accept, latency/busy check, optional backpressure with ignored pokes, handover.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [2*W-1:0] exp, input int hold, input bit poke);
    int edges;
    int busy_cnt;
    logic [2*W-1:0] p_hold;
    logic [2*W-1:0] want;
    @(negedge clk);
    chk("in_ready_idle", 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.a         = x;
    bus.b         = y;
    bus.sgn       = s;
    bus.out_ready = 1'b0;
    sb.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.sgn      = 1'($urandom);
    edges    = 0;
    busy_cnt = 0;
    while (!bus.out_valid && edges < W + 4) begin
      if (bus.busy) busy_cnt++;
      if (poke && edges == 2) bus.in_valid = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 64'(edges), 64'(W));
    chk("busy_cycles", 64'(busy_cnt), 64'(W));
    chk("busy_done", 64'(bus.busy), 64'(0));
    chk("in_ready_done", 64'(bus.in_ready), 64'(0));
    p_hold = bus.p;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_p_stable", 64'(bus.p), 64'(p_hold));
      chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid = 1'b0;
    chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      want = sb.pop_front();
      chk("product", 64'(bus.p), 64'(want));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 64'(bus.out_valid), 64'(0));
    chk("in_ready_back", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] corners [5];
    logic [W-1:0] x, y;
    logic s;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sgn       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_p", 64'(bus.p), 64'(0));
    rst = 1'b0;

    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b0);
    run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, 1'b0);
    run_op(8'h80, 8'h02, 1'b0, 16'h0100, 0, 1'b0);
    run_op(8'h80, 8'h02, 1'b1, 16'hFF00, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 16'h0000, 0, 1'b0);
    run_op(8'h03, 8'h08, 1'b0, 16'h0018, 5, 1'b1);

    // Asynchronous reset during RUN step 4 clears everything immediately.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'h7F;
    bus.b        = 8'h7F;
    bus.sgn      = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_p", 64'(bus.p), 64'(0));
    chk("arst_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(bus.out_valid), 64'(0));
    end
    run_op(8'h02, 8'h03, 1'b0, 16'h0006, 0, 1'b0);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int k = 0; k < 2; k++) begin
          s = 1'(k);
          run_op(corners[i], corners[j], s, ref_prod(corners[i], corners[j], s), 0, 1'b0);
        end

    for (int i = 0; i < 300; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      s = 1'($urandom);
      run_op(x, y, s, ref_prod(x, y, s), int'($urandom_range(0, 2)), 1'($urandom));
    end

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised, multi-cycle radix-2 shift-and-add multiplier. Processes one multiplier bit per clock.
- Supports unsigned or two's-complement operands, selected per operation.
- Uses valid/ready handshakes on both input and output so it sits directly in datapath pipelines as the clocked successor of the team's combinational 4-bit multiplier.
- Produces a full 2*WIDTH-bit product with no truncation or overflow.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), step counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b, sgn valid this cycle
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- sgn  input  1  1 = both operands two's complement; 0 = both unsigned
- out_valid  output  1  p holds a completed product
- out_ready  input  1  consumer accepts p this cycle
- p  output  2*WIDTH  product
- busy  output  1  high while RUN is active

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. While rst is high: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, internal accumulator/counter=0.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch a, b, sgn; clear accumulator; counter=0; go to RUN.
  - RUN: in_ready=0, busy=1. One step per edge, exactly WIDTH steps. After the step with counter==WIDTH-1: load p, go to DONE.
  - DONE: out_valid=1, p stable, busy=0, in_ready=0. On out_ready high at an edge: go to IDLE, out_valid=0. p keeps its last value until the next completion.
- Step arithmetic (q = multiplier shift register, acc = accumulator of at least WIDTH+2 bits):
  - If q[0]=1: add the multiplicand to acc. Sign-extend it if sgn=1, zero-extend if sgn=0.
  - Exception: if sgn=1 and this is the final step (multiplier MSB), subtract the multiplicand instead. This is the two's-complement weight of the MSB.
  - Then shift {acc,q} right by one. Arithmetic shift if sgn=1; logical shift (carry retained in acc extension) if sgn=0.
  - Result p = low 2*WIDTH bits of {acc,q} after WIDTH steps. Must equal the exact product a*b for every operand pair, including the most-negative values.
- Latency: accepting edge = edge 0. out_valid is high after edge WIDTH, i.e. in the cycle following edge WIDTH. With out_ready held high, in_ready returns high after edge WIDTH+1. Throughput: one product per WIDTH+2 cycles.
- Boundaries:
  - in_valid while RUN or DONE: ignored. Operands are not queued; the upstream must hold them until in_ready.
  - a, b, sgn changing during RUN: no effect (latched copies used).
  - Output backpressure: out_ready low holds DONE and p indefinitely.
  - Overlapping handshakes: input and output handshakes never occur in the same cycle (in_ready=0 in DONE).
  - Reset mid-RUN or mid-DONE: immediate return to reset values; the in-flight product is discarded, and no out_valid pulse follows reset deassertion.
  - Zero operands: the full WIDTH steps still run; no early termination.

Test Plan:
- WIDTH=8, sgn=0, a=0xFF, b=0xFF -> out_valid high 8 edges after accept, p=0xFE01; busy high for exactly 8 cycles.
- WIDTH=8, sgn=1, a=0x80 (-128), b=0x80 (-128) -> p=0x4000 (16384); and a=0xFD (-3), b=0x05 -> p=0xFFF1 (-15).
- WIDTH=8, sgn=0 vs sgn=1 with a=0x80, b=0x02 -> unsigned p=0x0100, signed p=0xFF00 (-256).
- Backpressure: out_ready held low 5 cycles after completion -> out_valid and p=0x0018 (a=3, b=8) stable throughout; in_ready stays 0; in_valid pulses during RUN and DONE are ignored; the next accept occurs only after out_ready.
- Reset: assert rst at RUN step 4 of a=0x7F, b=0x7F -> out_valid, busy, p go to 0 asynchronously. After release, the new operation a=0x02, b=0x03 gives p=0x0006 with no stale output.
- WIDTH=4 and WIDTH=16 randomized regression (10k ops each, mixed sgn) against a reference product -> zero mismatches; latency always WIDTH.
